cross_bar_slave_resp: RTL and testbench
=======================================

// Module: cross_bar_slave_resp
// PURPOSE
//  Response-direction companion of the per-slave request mux in the crossbar. It sits at each slave port
//  and routes slave_ack to the currently granted master. It remembers which master issued each accepted
//  read, in order, and steers the later slave_resp/slave_rdata back to that master. Read issue is throttled
//  when the tracking queue is full.
// PARAMETERS
//  OUTST_N   4                        max outstanding reads per slave (FIFO depth, power of 2, >=2)
//  MASTER_N  cross_bar_pkg::MASTER_N  number of masters (localparam)
//  MASTER_W  cross_bar_pkg::MASTER_W  $clog2(MASTER_N), master index width (localparam)
//  DATA_W    cross_bar_pkg::DATA_W    read data width (localparam)
// PORTS
//  clk            in   1                  single clock
//  aresetn        in   1                  asynchronous active-low reset
//  grant          in   MASTER_N           one-hot arbiter grant from this slave port's mux (all-zero = idle)
//  mux_req        in   1                  slave_req as produced by the request mux
//  mux_cmd        in   1                  slave_cmd from the mux (0 = read, 1 = write)
//  slave_req      out  1                  gated request to the slave
//  slave_ack      in   1                  slave accepted the current request
//  slave_resp     in   1                  read data valid from the slave, returned in issue order
//  slave_rdata    in   DATA_W             read data
//  master_ack     out  MASTER_N           ack routed to the granted master
//  master_resp    out  MASTER_N           read-valid routed to the issuing master
//  master_rdata   out  MASTER_N x DATA_W  read data, meaningful only where master_resp is set
//  rd_full        out  1                  tracking FIFO full (status)
//  resp_err       out  1                  sticky: slave_resp arrived with the FIFO empty
// BEHAVIOUR
//  Reset: FIFO empty, rd_full=0, resp_err=0. All outputs are 0 while aresetn=0.
//  Gating: slave_req = mux_req & ~(~mux_cmd & rd_full).
//   - Writes are never blocked.
//   - Reads are blocked while full, even if a pop happens in the same cycle (conservative, no bypass).
//  Ack: master_ack[i] = grant[i] & slave_ack & slave_req. This is combinational, in the same cycle as slave_ack.
//   - slave_ack while slave_req=0 is ignored.
//  Push: on slave_req & slave_ack & ~mux_cmd, write index(grant) into the FIFO at clk rise.
//   - index = binary encode of one-hot grant, MASTER_W bits.
//  Pop/route: on slave_resp with FIFO not empty, head = master id h. Then:
//   - master_resp[h] = 1 combinationally; master_rdata[h] = slave_rdata; every other lane is 0.
//   - Pop at clk rise.
//  Simultaneous push+pop: both happen and the count is unchanged. At count=1 the pop uses the old head,
//   and the new entry becomes the head.
//  Empty resp: slave_resp while empty -> no master_resp, set resp_err at the next edge. resp_err holds until reset.
//  Pointers: log2(OUTST_N)-bit wrap-around read/write pointers plus an extra wrap bit.
//   - full = ptr MSBs differ and the rest are equal; empty = all bits equal.
//   - rd_full is the registered full flag.
//  Count invariant: 0..OUTST_N, never overflows, because the push is gated by full.
//  Reset mid-operation: FIFO is flushed. Responses still in flight from the slave then hit an empty FIFO
//   and raise resp_err (intended diagnostic).
//  No state machine beyond the FIFO. Latency: ack 0 cycles, resp routing 0 cycles, FIFO update 1 edge.
// STRUCTURE
//  Shared package cross_bar_pkg gains:
//   - MASTER_W = $clog2(MASTER_N)
//   - typedef logic [MASTER_W-1:0] mid_t
//   - parameter OUTST_N default 4
//  Sub-module cross_bar_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
//   - ports: clk, aresetn, push, pop, wdata, rdata (head, combinational), full, empty.
//  Top level holds the gating, the one-hot->binary encoder, the ack/resp demux and the resp_err flop.
// TESTING (MASTER_N=4, OUTST_N=4, DATA_W=32)
//  1 Write: grant=0100, mux_req=1, mux_cmd=1, slave_ack=1 -> master_ack=0100 same cycle; FIFO stays empty.
//  2 Reads in order: reads acked from masters 0, 2, 3, then resp x3 with rdata A1, B2, C3
//     -> master_resp 0001/A1, 0100/B2, 1000/C3; FIFO empty at the end.
//  3 Full throttle: 4 reads acked, no resp -> rd_full=1.
//     - a 5th read with mux_req=1 -> slave_req=0 and master_ack=0.
//     - a write in the same state -> slave_req=1.
//     - one resp -> rd_full=0 next cycle.
//  4 Push+pop same cycle: at count=1 (head = master 1), read from master 2 acked together with resp D4
//     -> master_resp=0010/D4; count stays 1; the next resp goes to master 2.
//  5 Empty resp: slave_resp=1 with the FIFO empty -> master_resp=0, resp_err=1 next cycle and held.
//  6 Reset mid-op: 3 reads outstanding, pulse aresetn low -> rd_full=0, resp_err=0.
//     - the next slave_resp -> resp_err=1, no master_resp.

Source files
------------

// File: rtl/cross_bar_pkg.sv
`default_nettype none
// cross_bar_pkg: shared crossbar constants, master-id type and one-hot encoder.
// Revision: 1.0
package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int MASTER_W = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
    localparam int DATA_W   = 32;
    localparam int OUTST_N  = 4;

    typedef logic [MASTER_W-1:0] mid_t;

    function automatic mid_t onehot2bin(input logic [MASTER_N-1:0] oh);
        mid_t r;
        r = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            if (oh[i]) begin
                r = r | mid_t'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cross_bar_fifo.sv
`default_nettype none
// cross_bar_fifo: synchronous FIFO with combinational head and wrap-bit pointers.
// Revision: 1.0
module cross_bar_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_ptr_one = {{PTR_W{1'b0}}, 1'b1};

    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    // Guards keep the count within 0..DEPTH even if a caller misbehaves.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[r_rptr[PTR_W-1:0]];
    assign full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign empty = (r_wptr == r_rptr);

endmodule
`default_nettype wire

// File: rtl/cross_bar_slave_resp.sv
`default_nettype none
// cross_bar_slave_resp: per-slave ack routing and in-order read response steering.
// Revision: 1.0
module cross_bar_slave_resp
    import cross_bar_pkg::*;
#(
    parameter int OUTST_N = cross_bar_pkg::OUTST_N
) (
    input  logic                           clk,
    input  logic                           aresetn,
    input  logic [MASTER_N-1:0]            grant,
    input  logic                           mux_req,
    input  logic                           mux_cmd,
    output logic                           slave_req,
    input  logic                           slave_ack,
    input  logic                           slave_resp,
    input  logic [DATA_W-1:0]              slave_rdata,
    output logic [MASTER_N-1:0]            master_ack,
    output logic [MASTER_N-1:0]            master_resp,
    output logic [MASTER_N-1:0][DATA_W-1:0] master_rdata,
    output logic                           rd_full,
    output logic                           resp_err
);

    logic w_full;
    logic w_empty;
    logic w_accept;
    logic w_push;
    logic w_pop;
    mid_t w_head;
    mid_t w_grant_id;
    logic r_resp_err;

    // Reads stall whenever the tracker is full, even if it drains this cycle.
    assign slave_req  = aresetn & mux_req & ~(~mux_cmd & w_full);
    assign w_accept   = slave_req & slave_ack;
    assign master_ack = grant & {MASTER_N{w_accept}};
    assign w_grant_id = onehot2bin(grant);
    assign w_push     = w_accept & ~mux_cmd;
    assign w_pop      = aresetn & slave_resp & ~w_empty;

    cross_bar_fifo #(
        .WIDTH (MASTER_W),
        .DEPTH (OUTST_N)
    ) u_fifo (
        .clk     (clk),
        .aresetn (aresetn),
        .push    (w_push),
        .pop     (w_pop),
        .wdata   (w_grant_id),
        .rdata   (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_comb begin
        master_resp  = '0;
        master_rdata = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            if (w_pop && (w_head == mid_t'(i))) begin
                master_resp[i]  = 1'b1;
                master_rdata[i] = slave_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_resp_err <= 1'b0;
        end else if (slave_resp && w_empty) begin
            r_resp_err <= 1'b1;
        end
    end

    assign rd_full  = w_full;
    assign resp_err = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_cross_bar_slave_resp.sv
`default_nettype none
// tb_cross_bar_slave_resp: table-driven bench for the slave response router.
// Revision: 1.0
module tb_cross_bar_slave_resp;
    import cross_bar_pkg::*;

    logic                       clk = 1'b0;
    logic                       aresetn;
    logic [3:0]                 grant;
    logic                       mux_req;
    logic                       mux_cmd;
    logic                       slave_req;
    logic                       slave_ack;
    logic                       slave_resp;
    logic [31:0]                slave_rdata;
    logic [3:0]                 master_ack;
    logic [3:0]                 master_resp;
    logic [3:0][31:0]           master_rdata;
    logic                       rd_full;
    logic                       resp_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cross_bar_slave_resp #(.OUTST_N(4)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .grant        (grant),
        .mux_req      (mux_req),
        .mux_cmd      (mux_cmd),
        .slave_req    (slave_req),
        .slave_ack    (slave_ack),
        .slave_resp   (slave_resp),
        .slave_rdata  (slave_rdata),
        .master_ack   (master_ack),
        .master_resp  (master_resp),
        .master_rdata (master_rdata),
        .rd_full      (rd_full),
        .resp_err     (resp_err)
    );

    typedef struct {
        logic [3:0]  grant;
        logic        req;
        logic        cmd;
        logic        ack;
        logic        resp;
        logic [31:0] rdata;
        logic        e_sreq;
        logic [3:0]  e_ack;
        logic [3:0]  e_resp;
        logic        e_full;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] g, input logic rq, input logic cm,
                                input logic ak, input logic rs, input logic [31:0] rd,
                                input logic es, input logic [3:0] ea, input logic [3:0] er,
                                input logic ef, input logic ee);
        vec_t v;
        v.grant = g; v.req = rq; v.cmd = cm; v.ack = ak; v.resp = rs; v.rdata = rd;
        v.e_sreq = es; v.e_ack = ea; v.e_resp = er; v.e_full = ef; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] g, input logic rq, input logic cm,
                         input logic ak, input logic rs, input logic [31:0] rd);
        grant = g; mux_req = rq; mux_cmd = cm; slave_ack = ak; slave_resp = rs; slave_rdata = rd;
    endtask

    task automatic idle();
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 aresetn = 1'b0;
        #2;
        check("rst_sreq", 128'(slave_req), 128'(0));
        check("rst_full", 128'(rd_full), 128'(0));
        check("rst_err", 128'(resp_err), 128'(0));
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    logic [127:0] exp_rd;

    initial begin
        // Test 1: write acked, FIFO untouched.
        vecs.push_back(mk(4'b0100, 1, 1, 1, 0, 32'h0,  1, 4'b0100, 4'b0000, 0, 0));
        // Test 2: three reads then in-order responses.
        vecs.push_back(mk(4'b0001, 1, 0, 1, 0, 32'h0,  1, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0100, 1, 0, 1, 0, 32'h0,  1, 4'b0100, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 1, 0, 32'h0,  1, 4'b1000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'hA1, 0, 4'b0000, 4'b0001, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'hB2, 0, 4'b0000, 4'b0100, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'hC3, 0, 4'b0000, 4'b1000, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 32'h0,  0, 4'b0000, 4'b0000, 0, 0));
        // Test 3: fill, throttle reads, pass writes, drain.
        vecs.push_back(mk(4'b0001, 1, 0, 1, 0, 32'h0,  1, 4'b0001, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0010, 1, 0, 1, 0, 32'h0,  1, 4'b0010, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0100, 1, 0, 1, 0, 32'h0,  1, 4'b0100, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b1000, 1, 0, 1, 0, 32'h0,  1, 4'b1000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 1, 0, 32'h0,  0, 4'b0000, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0010, 1, 1, 1, 0, 32'h0,  1, 4'b0010, 4'b0000, 1, 0));
        vecs.push_back(mk(4'b0001, 1, 0, 1, 1, 32'h55, 0, 4'b0000, 4'b0001, 1, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 32'h0,  0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'h66, 0, 4'b0000, 4'b0010, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'h77, 0, 4'b0000, 4'b0100, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'h88, 0, 4'b0000, 4'b1000, 0, 0));
        // Test 4: push and pop together at count 1.
        vecs.push_back(mk(4'b0010, 1, 0, 1, 0, 32'h0,  1, 4'b0010, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0100, 1, 0, 1, 1, 32'hD4, 1, 4'b0100, 4'b0010, 0, 0));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'hE5, 0, 4'b0000, 4'b0100, 0, 0));
        // Test 5: response with empty FIFO sets sticky error; stray ack ignored.
        vecs.push_back(mk(4'b0000, 0, 0, 0, 1, 32'hF6, 0, 4'b0000, 4'b0000, 0, 0));
        vecs.push_back(mk(4'b0001, 0, 0, 1, 0, 32'h0,  0, 4'b0000, 4'b0000, 0, 1));
        vecs.push_back(mk(4'b0000, 0, 0, 0, 0, 32'h0,  0, 4'b0000, 4'b0000, 0, 1));

        // Outputs must be quiet during reset even with active inputs.
        aresetn = 1'b0;
        drive(4'b0001, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD);
        #2;
        check("init_sreq", 128'(slave_req), 128'(0));
        check("init_ack", 128'(master_ack), 128'(0));
        check("init_resp", 128'(master_resp), 128'(0));
        check("init_full", 128'(rd_full), 128'(0));
        check("init_err", 128'(resp_err), 128'(0));
        @(negedge clk);
        idle();
        aresetn = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].grant, vecs[k].req, vecs[k].cmd, vecs[k].ack, vecs[k].resp, vecs[k].rdata);
            #2;
            exp_rd = '0;
            for (int j = 0; j < 4; j++) begin
                if (vecs[k].e_resp[j]) exp_rd[j*32 +: 32] = vecs[k].rdata;
            end
            check($sformatf("v%0d_sreq", k), 128'(slave_req), 128'(vecs[k].e_sreq));
            check($sformatf("v%0d_ack", k), 128'(master_ack), 128'(vecs[k].e_ack));
            check($sformatf("v%0d_resp", k), 128'(master_resp), 128'(vecs[k].e_resp));
            check($sformatf("v%0d_rdata", k), master_rdata, exp_rd);
            check($sformatf("v%0d_full", k), 128'(rd_full), 128'(vecs[k].e_full));
            check($sformatf("v%0d_err", k), 128'(resp_err), 128'(vecs[k].e_err));
        end

        // Test 6: flush with reads outstanding, then a stray response.
        idle();
        reset_pulse();
        for (int m = 0; m < 3; m++) begin
            @(negedge clk);
            drive(4'b0001 << m, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            #2;
            check("t6_ack", 128'(master_ack), 128'(4'b0001 << m));
        end
        @(negedge clk);
        drive(4'b0001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        #1 aresetn = 1'b0;
        #2;
        check("t6_rst_sreq", 128'(slave_req), 128'(0));
        check("t6_rst_ack", 128'(master_ack), 128'(0));
        @(negedge clk);
        idle();
        aresetn = 1'b1;
        #2;
        check("t6_full", 128'(rd_full), 128'(0));
        check("t6_err0", 128'(resp_err), 128'(0));
        @(negedge clk);
        drive(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        #2;
        check("t6_resp", 128'(master_resp), 128'(0));
        check("t6_rdata", master_rdata, 128'(0));
        @(negedge clk);
        idle();
        #2;
        check("t6_err1", 128'(resp_err), 128'(1));
        @(negedge clk);
        #2;
        check("t6_err_hold", 128'(resp_err), 128'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
